pattgen_capture: RTL
====================

Name: pattgen_capture

Overview:
- Loopback receiver placed directly downstream of the pattern generator. It consumes one channel's clock/data pin pair (pcl/pda) and deserializes the bit stream into words.
- Completed words are buffered in a small FIFO and offered on a valid/ready interface to the DV/self-test logic.
- The block checks generator output on-chip and provides a functional model for chip-level pattern tests.

Parameters:
- DataWidth, 32, maximum bits per captured word (power of 2, 8..64).
- FifoDepth, 4, number of buffered words (power of 2, >=2).
- TimeoutW, 16, width of the idle-timeout counter.

Ports:
- clk_i  in  1  block clock
- rst_i  in  1  asynchronous active-high reset
- pcl_i  in  1  pattern clock pin, asynchronous to clk_i
- pda_i  in  1  pattern data pin, asynchronous to clk_i
- enable_i  in  1  capture enable (level)
- polarity_i  in  1  0: sample pda on pcl rising edge; 1: sample on falling edge
- len_i  in  $clog2(DataWidth)  bits per word minus 1
- timeout_i  in  TimeoutW  idle clk cycles before a partial word is flushed; 0 disables
- clear_i  in  1  single-cycle pulse: flush FIFO, discard partial word, clear overflow
- word_o  out  DataWidth  FIFO head word; first-received bit is in the LSB; unfilled bits are 0
- word_bits_o  out  $clog2(DataWidth)+1  number of valid bits in word_o
- word_valid_o  out  1  FIFO not empty
- word_ready_i  in  1  consumer accepts the head word
- overflow_o  out  1  sticky flag: a completed word was dropped
- fifo_lvl_o  out  $clog2(FifoDepth)+1  FIFO occupancy
- busy_o  out  1  partial word in progress (bit count > 0)

Behaviour:
- Reset values: all outputs 0; synchronizers, edge register, shift register, counters and FIFO pointers cleared.
- Input synchronization: pcl_i and pda_i each pass through a 2-flop synchronizer. pcl_prev holds the synchronized pcl delayed by one cycle.
- Sample edge:
  - polarity_i=0: sync_pcl & ~pcl_prev.
  - polarity_i=1: ~sync_pcl & pcl_prev.
  - Sample edges are qualified by enable_i.
- States:
  - IDLE: bit_cnt=0, timer off.
  - SHIFT: at least one bit held.
  - There is no separate push state; a push is a single-cycle action.
- Transitions:
  - IDLE --sample--> SHIFT: bit0 = sync_pda.
  - If len_i==0, the first sample pushes immediately and the FSM stays in IDLE.
  - SHIFT --sample, bit_cnt==len_i--> push word with word_bits = len_i+1; go to IDLE.
  - SHIFT --timer==timeout_i (timeout_i!=0)--> push partial word with word_bits = bit_cnt; go to IDLE.
  - Any state --~enable_i or clear_i--> IDLE; partial word discarded, no push.
- Timer: resets to 0 on every sample edge and increments each cycle in SHIFT. It saturates and never wraps.
- len_i changes: len_i is sampled every cycle. If len_i drops below the current bit_cnt, the next sample edge completes the word with word_bits = bit_cnt+1.
- Latency: a pcl pin edge that completes a word produces word_valid_o=1 after exactly 4 clk_i rising edges (2 sync, 1 edge-detect register, 1 FIFO write).
- FIFO handshake:
  - Pop occurs when word_valid_o & word_ready_i.
  - word_o and word_bits_o are stable while word_valid_o=1 and no pop occurs.
- FIFO full:
  - A push while full with no same-cycle pop drops the new word and sets overflow_o.
  - A push while full with a same-cycle pop succeeds; occupancy is unchanged.
- Empty: a pop with word_valid_o=0 is ignored. Pointers wrap modulo FifoDepth.
- clear_i:
  - Takes priority over a same-cycle push and pop.
  - Next cycle: fifo_lvl_o=0, overflow_o=0, busy_o=0.
- Reset mid-word: asynchronous; all state is cleared immediately with no output glitch beyond the reset values.
- Synchronizer cells use the team's standard 2-flop primitive.

Test Plan:
- len_i=7, polarity_i=0, drive pcl with 8 rising edges carrying pda bits 1,0,1,1,0,0,1,0 (pcl period 8 clk) -> word_o=0x4D, word_bits_o=8, word_valid_o rises 4 clk after the 8th edge; a pop with ready clears it.
- polarity_i=1, len_i=3, bits 1,1,0,1 on falling edges -> word_o=0xB, word_bits_o=4; the rising edges cause no capture.
- timeout_i=20, len_i=31, send 5 bits 1,1,1,1,1 then hold pcl -> 20 cycles after the last edge, push word_o=0x1F, word_bits_o=5, busy_o=0.
- FifoDepth=4, word_ready_i=0, send 5 complete words -> fifo_lvl_o=4, the 5th word is dropped, overflow_o=1; assert clear_i -> fifo_lvl_o=0, overflow_o=0.
- FIFO full with word_ready_i=1 in the same cycle a word completes -> the pop and push both occur, fifo_lvl_o stays 4, overflow_o stays 0.
- Deassert enable_i (then rst_i) after 3 bits of an 8-bit word -> busy_o=0 and no push. A subsequent 8-bit word is captured correctly from bit 0; reset forces all outputs to 0 asynchronously.

Source files
------------

// File: rtl/pattgen_capture.sv
// Loopback deserializer for one pattern-generator channel: synchronizes pcl/pda,
// assembles LSB-first words and buffers them in a small FIFO behind valid/ready.
module pattgen_capture #(
    parameter int DataWidth = 32,
    parameter int FifoDepth = 4,
    parameter int TimeoutW  = 16,
    localparam int LenW = $clog2(DataWidth),
    localparam int PtrW = $clog2(FifoDepth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pcl_i,
    input  logic                 pda_i,
    input  logic                 enable_i,
    input  logic                 polarity_i,
    input  logic [LenW-1:0]      len_i,
    input  logic [TimeoutW-1:0]  timeout_i,
    input  logic                 clear_i,
    output logic [DataWidth-1:0] word_o,
    output logic [LenW:0]        word_bits_o,
    output logic                 word_valid_o,
    input  logic                 word_ready_i,
    output logic                 overflow_o,
    output logic [PtrW:0]        fifo_lvl_o,
    output logic                 busy_o
);

    typedef enum logic {IDLE, SHIFT} state_e;

    logic pcl_meta_p0, pcl_sync_p1, pcl_prev_p2;
    logic pda_meta_p0, pda_sync_p1, pda_p2;
    logic smp_vld_p2;

    state_e                state_q, state_d;
    logic [LenW:0]         bit_cnt_q, bit_cnt_d;
    logic [DataWidth-1:0]  shift_q, shift_d, shift_ins;
    logic [TimeoutW-1:0]   timer_q, timer_d;
    logic                  sample;
    logic                  push;
    logic [DataWidth-1:0]  push_word;
    logic [LenW:0]         push_bits;

    logic [DataWidth-1:0]  mem_word [FifoDepth];
    logic [LenW:0]         mem_bits [FifoDepth];
    logic [PtrW:0]         wr_ptr_q, rd_ptr_q, lvl;
    logic                  full, do_pop, do_push, ovf_q;

    // Stage p0/p1: 2-flop synchronizers; p2: registered edge detect with aligned data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcl_meta_p0 <= 1'b0;
            pcl_sync_p1 <= 1'b0;
            pcl_prev_p2 <= 1'b0;
            pda_meta_p0 <= 1'b0;
            pda_sync_p1 <= 1'b0;
            pda_p2      <= 1'b0;
            smp_vld_p2  <= 1'b0;
        end else begin
            pcl_meta_p0 <= pcl_i;
            pcl_sync_p1 <= pcl_meta_p0;
            pcl_prev_p2 <= pcl_sync_p1;
            pda_meta_p0 <= pda_i;
            pda_sync_p1 <= pda_meta_p0;
            pda_p2      <= pda_sync_p1;
            smp_vld_p2  <= polarity_i ? (~pcl_sync_p1 & pcl_prev_p2)
                                      : (pcl_sync_p1 & ~pcl_prev_p2);
        end
    end

    assign sample    = smp_vld_p2 & enable_i;
    assign shift_ins = shift_q | (DataWidth'(pda_p2) << bit_cnt_q[LenW-1:0]);

    // Stage p3: word assembly FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        timer_d   = timer_q;
        push      = 1'b0;
        push_word = '0;
        push_bits = '0;
        if (clear_i || !enable_i) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            timer_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample) begin
                        if (len_i == '0) begin
                            push      = 1'b1;
                            push_word = DataWidth'(pda_p2);
                            push_bits = (LenW+1)'(1);
                        end else begin
                            state_d   = SHIFT;
                            bit_cnt_d = (LenW+1)'(1);
                            shift_d   = DataWidth'(pda_p2);
                            timer_d   = '0;
                        end
                    end
                end
                SHIFT: begin
                    // A len_i lowered below the bit count completes on the next sample
                    if (sample && (bit_cnt_q >= {1'b0, len_i})) begin
                        push      = 1'b1;
                        push_word = shift_ins;
                        push_bits = bit_cnt_q + (LenW+1)'(1);
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        timer_d   = '0;
                    end else if (sample) begin
                        shift_d   = shift_ins;
                        bit_cnt_d = bit_cnt_q + (LenW+1)'(1);
                        timer_d   = '0;
                    end else if ((timeout_i != '0) && (timer_q == timeout_i)) begin
                        push      = 1'b1;
                        push_word = shift_q;
                        push_bits = bit_cnt_q;
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        timer_d   = '0;
                    end else if (timer_q != '1) begin
                        timer_d = timer_q + TimeoutW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy_o = (bit_cnt_q != '0);

    // Stage p4: output FIFO; a pop frees a slot for a same-cycle push when full
    assign lvl          = wr_ptr_q - rd_ptr_q;
    assign full         = (lvl == (PtrW+1)'(FifoDepth));
    assign word_valid_o = (lvl != '0);
    assign do_pop       = word_valid_o & word_ready_i & ~clear_i;
    assign do_push      = push & ~clear_i & (~full | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
            if (push && full && !do_pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_word[wr_ptr_q[PtrW-1:0]] <= push_word;
            mem_bits[wr_ptr_q[PtrW-1:0]] <= push_bits;
        end
    end

    // Storage is not reset, so the head is masked to keep outputs at 0 when empty
    assign word_o      = word_valid_o ? mem_word[rd_ptr_q[PtrW-1:0]] : '0;
    assign word_bits_o = word_valid_o ? mem_bits[rd_ptr_q[PtrW-1:0]] : '0;
    assign overflow_o  = ovf_q;
    assign fifo_lvl_o  = lvl;

endmodule
